// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline-stage payload definitions and bubble encodings for pipe_stage_buf instances.
package pipe_stage_buf_pkg;

  localparam logic [31:0] NOP_INST       = 32'h13;
  localparam logic [63:0] DEFAULT_BUBBLE = 64'(NOP_INST);

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } id_ex_t;

  // Bubbles decode as ADDI x0,x0,0 so a drained stage behaves as a NOP.
  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b      = '0;
    b.inst = NOP_INST;
    return b;
  endfunction

  function automatic id_ex_t id_ex_bubble();
    id_ex_t b;
    b        = '0;
    b.opcode = 7'h13;
    return b;
  endfunction

endpackage

// File: rtl/pipe_buf_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port, no reset.
module pipe_buf_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline register with valid/ready backpressure, synchronous flush and bubble output.
// Define PIPE_STAGE_BUF_PERF_EN to add saturating stall/flush cycle counters.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int               WIDTH  = 64,
  parameter int               DEPTH  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(DEFAULT_BUBBLE)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush_i,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef PIPE_STAGE_BUF_PERF_EN
  ,
  output logic [31:0]                stall_cnt_o,
  output logic [31:0]                flush_cnt_o
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop, ram_we;
  logic [WIDTH-1:0] rd_data;
  occ_e             occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    occ = OCC_PARTIAL;
    if (count == '0)               occ = OCC_EMPTY;
    else if (count == CW'(DEPTH))  occ = OCC_FULL;
  end

  // Ready depends only on occupancy, so a full buffer refuses even when popping.
  assign in_ready  = (occ != OCC_FULL);
  assign out_valid = (occ != OCC_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign ram_we    = push & ~flush_i & ~RST;
  assign out_data  = out_valid ? rd_data : BUBBLE;
  assign count_o   = count;

  always_ff @(posedge CLK) begin
    if (RST || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  pipe_buf_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

`ifdef PIPE_STAGE_BUF_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (in_valid && !in_ready && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_i && flush_cnt_o != '1)               flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

  always @(posedge CLK) begin
    if (!RST) begin
      assert (count <= CW'(DEPTH));
      assert (!(ram_we && !in_ready));
      assert (!(pop && !out_valid));
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: DEPTH=2 and DEPTH=3 instances share stimulus.
module tb_pipe_stage_buf;

  localparam logic [63:0] BUB = 64'h13;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        in_ready2, out_valid2, in_ready3, out_valid3;
  logic [63:0] out_data2, out_data3;
  logic [1:0]  count2, count3;
`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [31:0] stall2, flush2, stall3, flush3;
`endif

  int checks = 0;
  int errors = 0;
  bit model_ok = 0;
  logic [63:0] q2[$];
  logic [63:0] q3[$];

  always #5 CLK = ~CLK;

  pipe_stage_buf #(.WIDTH(64), .DEPTH(2)) dut2 (
    .CLK(CLK), .RST(RST), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .count_o(count2)
`ifdef PIPE_STAGE_BUF_PERF_EN
    , .stall_cnt_o(stall2), .flush_cnt_o(flush2)
`endif
  );

  pipe_stage_buf #(.WIDTH(64), .DEPTH(3)) dut3 (
    .CLK(CLK), .RST(RST), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .count_o(count3)
`ifdef PIPE_STAGE_BUF_PERF_EN
    , .stall_cnt_o(stall3), .flush_cnt_o(flush3)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a bounded FIFO queue; flush/reset empty it, a full queue refuses pushes.
  task automatic model_edge();
    bit pop2, push2, pop3, push3;
    if (RST || flush_i) begin
      q2.delete();
      q3.delete();
      if (RST) model_ok = 1;
    end else begin
      pop2  = out_ready && q2.size() != 0;
      push2 = in_valid && q2.size() != 2;
      pop3  = out_ready && q3.size() != 0;
      push3 = in_valid && q3.size() != 3;
      if (pop2)  void'(q2.pop_front());
      if (push2) q2.push_back(in_data);
      if (pop3)  void'(q3.pop_front());
      if (push3) q3.push_back(in_data);
    end
  endtask

  task automatic model_check();
    if (model_ok) begin
      chk("d2_valid", {63'd0, out_valid2}, {63'd0, q2.size() != 0});
      chk("d2_data",  out_data2, (q2.size() != 0) ? q2[0] : BUB);
      chk("d2_ready", {63'd0, in_ready2}, {63'd0, q2.size() != 2});
      chk("d2_count", 64'(count2), 64'(q2.size()));
      chk("d3_valid", {63'd0, out_valid3}, {63'd0, q3.size() != 0});
      chk("d3_data",  out_data3, (q3.size() != 0) ? q3[0] : BUB);
      chk("d3_ready", {63'd0, in_ready3}, {63'd0, q3.size() != 3});
      chk("d3_count", 64'(count3), 64'(q3.size()));
    end
  endtask

  task automatic step();
    @(negedge CLK);
    model_check();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic        rst, flush, iv;
    logic [63:0] din;
    logic        ordy;
    logic        ev;
    logic [63:0] ed;
    logic        er;
    int          ec;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic flush, input logic iv,
                              input logic [63:0] din, input logic ordy, input logic ev,
                              input logic [63:0] ed, input logic er, input int ec);
    vec_t v;
    v.rst = rst; v.flush = flush; v.iv = iv; v.din = din; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.er = er; v.ec = ec;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    // Expected values describe dut2 (DEPTH=2) just after the edge that applied the row.
    tbl[0]  = mk(1, 0, 0, 64'h0,  0, 0, BUB,    1, 0);
    tbl[1]  = mk(1, 0, 0, 64'h0,  1, 0, BUB,    1, 0);
    tbl[2]  = mk(0, 0, 1, 64'hA1, 1, 1, 64'hA1, 1, 1);
    tbl[3]  = mk(0, 0, 1, 64'hA2, 1, 1, 64'hA2, 1, 1);
    tbl[4]  = mk(0, 0, 1, 64'hA3, 1, 1, 64'hA3, 1, 1);
    tbl[5]  = mk(0, 0, 0, 64'h0,  1, 0, BUB,    1, 0);
    tbl[6]  = mk(0, 0, 1, 64'hB1, 0, 1, 64'hB1, 1, 1);
    tbl[7]  = mk(0, 0, 1, 64'hB2, 0, 1, 64'hB1, 0, 2);
    tbl[8]  = mk(0, 0, 1, 64'hB3, 0, 1, 64'hB1, 0, 2);
    tbl[9]  = mk(0, 0, 1, 64'hB3, 1, 1, 64'hB2, 1, 1);
    tbl[10] = mk(0, 0, 1, 64'hB3, 1, 1, 64'hB3, 1, 1);
    tbl[11] = mk(0, 0, 0, 64'h0,  1, 0, BUB,    1, 0);
    tbl[12] = mk(0, 0, 1, 64'hC1, 0, 1, 64'hC1, 1, 1);
    tbl[13] = mk(0, 0, 1, 64'hC2, 0, 1, 64'hC1, 0, 2);
    tbl[14] = mk(0, 1, 1, 64'hC3, 1, 0, BUB,    1, 0);
    tbl[15] = mk(0, 0, 0, 64'h0,  1, 0, BUB,    1, 0);
    tbl[16] = mk(0, 0, 1, 64'hD1, 0, 1, 64'hD1, 1, 1);
    tbl[17] = mk(0, 1, 1, 64'hD2, 1, 0, BUB,    1, 0);
    tbl[18] = mk(0, 0, 0, 64'h0,  1, 0, BUB,    1, 0);

    for (int i = 0; i < 19; i++) begin
      RST = tbl[i].rst; flush_i = tbl[i].flush; in_valid = tbl[i].iv;
      in_data = tbl[i].din; out_ready = tbl[i].ordy;
      step();
      chk($sformatf("tbl%0d_valid", i), {63'd0, out_valid2}, {63'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_data", i),  out_data2, tbl[i].ed);
      chk($sformatf("tbl%0d_ready", i), {63'd0, in_ready2}, {63'd0, tbl[i].er});
      chk($sformatf("tbl%0d_count", i), 64'(count2), 64'(tbl[i].ec));
    end

    // Wrap-around on the DEPTH=3 instance: alternating stalls, upstream holds until accepted.
    begin
      int seq = 0;
      RST = 0; flush_i = 0;
      for (int i = 0; i < 10; i++) begin
        in_valid  = 1'b1;
        in_data   = 64'hE0 + 64'(seq);
        out_ready = i[0];
        if (q3.size() != 3) seq++;
        step();
        chk("wrap_count_le3", {63'd0, count3 <= 2'd3 && count3 == 2'(q3.size())}, 64'd1);
      end
      in_valid = 0; out_ready = 1;
      for (int i = 0; i < 4; i++) step();
      chk("wrap_drained", 64'(count3), 64'd0);
    end

    // Randomised traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      RST       = ($urandom_range(0, 199) == 0);
      flush_i   = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 5);
      in_data   = {$urandom, $urandom};
      step();
    end

`ifdef PIPE_STAGE_BUF_PERF_EN
    RST = 1; flush_i = 0; in_valid = 0; out_ready = 0;
    step();
    RST = 0; in_valid = 1; in_data = 64'hF1;
    step();
    in_data = 64'hF2;
    step();
    in_data = 64'hF3;
    for (int i = 0; i < 5; i++) step();
    in_valid = 0; flush_i = 1;
    step();
    step();
    flush_i = 0;
    step();
    chk("perf_stall", 64'(stall2), 64'd5);
    chk("perf_flush", 64'(flush2), 64'd2);
    RST = 1;
    step();
    RST = 0;
    chk("perf_stall_rst", 64'(stall2), 64'd0);
    chk("perf_flush_rst", 64'(flush2), 64'd0);
`endif

    RST = 0; flush_i = 0; in_valid = 0; out_ready = 0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
